// File: rtl/shift_pkg.sv
// Shared types and constants for the serial shift blocks (piso_serializer and shift_reg).
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage : shift_pkg

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// Emits one bit per enabled clock, MSB-first or LSB-first, with no gap between back-to-back words.
module piso_serializer
    import shift_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               dir_q,   dir_d;
    logic               last_bit;
    logic [WIDTH-1:0]   shreg_shifted;

    // Move the remaining bits toward the output end, zero-filling the vacated end.
    always_comb begin
        if (dir_q == DIR_LSB_FIRST) begin
            shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end else begin
            shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    assign last_bit = (cnt_q == '0);

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        load_ready = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        sout_last  = 1'b0;
        busy       = 1'b0;

        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
            end
            SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = (dir_q == DIR_LSB_FIRST) ? shreg_q[0] : shreg_q[WIDTH-1];
                sout_last  = last_bit;
                load_ready = last_bit & en;
                if (en) begin
                    shreg_d = shreg_shifted;
                    if (last_bit) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new word overrides the return to IDLE, giving gap-free back-to-back transfers.
        if (load_valid && load_ready) begin
            shreg_d = din;
            dir_d   = dir;
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_MSB_FIRST;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

endmodule : piso_serializer

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out shift register: the transmit-side counterpart of the team's serial-in, parallel-out shift_reg.
- Accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled clock, MSB-first or LSB-first.
- Output pins (sout/sout_valid/sout_last/en) are shaped to drive a shift_reg instance bit-for-bit.
- Sits between a word-wide producer and a 1-bit serial link.

Parameters:
- WIDTH, 16, word length in bits (>=2)
- CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- din  input  WIDTH  parallel word to serialize
- dir  input  1  shift order, sampled at load: 0 = MSB-first (shift left), 1 = LSB-first (shift right)
- load_valid  input  1  producer has a word on din
- load_ready  output  1  serializer can accept a word this cycle
- en  input  1  shift enable; 0 stalls the serializer in place
- sout  output  1  current serial bit
- sout_valid  output  1  sout carries a data bit
- sout_last  output  1  sout is the final bit of the word
- busy  output  1  word in flight (state == SHIFT)

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset=1 at an edge forces state=IDLE, shreg=0, cnt=0, dir_q=0. This holds even mid-word; the partial word is discarded with no sout_last.
- Outputs after reset: load_ready=1, sout=0, sout_valid=0, sout_last=0, busy=0.
- States (package enum): IDLE, SHIFT.
- IDLE:
  - load_ready=1; sout=0; sout_valid=0.
  - Load accept (load_valid & load_ready): shreg<=din, dir_q<=dir, cnt<=WIDTH-1, go to SHIFT.
  - The first bit is visible the cycle after accept.
- SHIFT:
  - sout = dir_q ? shreg[0] : shreg[WIDTH-1].
  - sout_valid=1; sout_last = (cnt==0).
- Bit consumption in SHIFT:
  - A bit is consumed at an edge with en=1.
  - On consumption: shreg shifts toward the output end, 0 fills the vacated end, cnt<=cnt-1.
  - en=0 holds shreg, cnt and the outputs unchanged for any number of cycles.
- load_ready in SHIFT:
  - load_ready = (cnt==0) & en, combinational; this allows back-to-back words.
  - If load_valid=1 at that edge: reload shreg/dir_q/cnt from din/dir and stay in SHIFT. The new word's first bit follows the previous last bit with no gap.
  - Otherwise return to IDLE; sout_valid drops the next cycle.
- Ignored inputs:
  - load_valid while load_ready=0 is ignored. The producer must hold din/load_valid until accepted.
  - dir changes during SHIFT are ignored; dir_q governs the whole word.
- Latency and throughput:
  - Accept to first bit: 1 cycle.
  - Word duration: WIDTH enabled cycles.
  - Sustained rate: 1 bit/clk with en held at 1.
- en in IDLE has no effect. Load is accepted regardless of en.
- Simultaneous reset and load_valid: reset wins; the word is not accepted.

Decomposition:
- Shared package (shift_pkg): state enum {IDLE, SHIFT}, constants DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1.
- Single module; no sub-module. The counter and shifter are each a few lines.

Test Plan:
- Reset, then WIDTH=16, din=16'hA5C3, dir=0, en=1 -> sout = 1010_0101_1100_0011 on the 16 cycles after accept. sout_last=1 only on the 16th; load_ready=1 again on the cycle after the last bit.
- Same word, dir=1 -> sout = 1100_0011_1010_0101 (LSB-first); sout_valid high exactly 16 cycles.
- Stall: en=0 for 3 cycles after bit 5 of 16'hA5C3 (dir=0) -> sout holds bit 5 (1) for those cycles; sequence then resumes intact; total word time = 19 cycles.
- Back-to-back: load_valid held with 16'hFFFF then 16'h0000 (dir=0) -> 16 ones immediately followed by 16 zeros, no idle gap. Second accept occurs on the same edge the first word's sout_last is consumed.
- Reset mid-word: assert reset at bit 8 of 16'hA5C3 -> next cycle sout=0, sout_valid=0, busy=0, load_ready=1; a fresh load of 16'h0001 (dir=1) then emits 1 followed by 15 zeros.
- Busy ignore: during a word, pulse load_valid with din=16'h1234 while load_ready=0 -> no change to the in-flight bit stream; 16'h1234 is not transmitted.
